// File: rtl/alu_arbiter_if.sv
// Bundle of both requester channels, the ALU hookup and the response channel.
// The arbiter takes the slave view; requesters, ALU and consumer take master.
interface alu_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int MODE_W = 4
);
  logic              r0_valid;
  logic              r0_ready;
  logic [DATA_W-1:0] r0_a;
  logic [DATA_W-1:0] r0_b;
  logic [MODE_W-1:0] r0_mode;

  logic              r1_valid;
  logic              r1_ready;
  logic [DATA_W-1:0] r1_a;
  logic [DATA_W-1:0] r1_b;
  logic [MODE_W-1:0] r1_mode;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [MODE_W-1:0] alu_mode;
  logic [DATA_W-1:0] alu_out;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;

  modport slave (
    input  r0_valid, r0_a, r0_b, r0_mode,
    output r0_ready,
    input  r1_valid, r1_a, r1_b, r1_mode,
    output r1_ready,
    output alu_a, alu_b, alu_mode,
    input  alu_out,
    output rsp_valid, rsp_id, rsp_data,
    input  rsp_ready
  );

  modport master (
    output r0_valid, r0_a, r0_b, r0_mode,
    input  r0_ready,
    output r1_valid, r1_a, r1_b, r1_mode,
    input  r1_ready,
    input  alu_a, alu_b, alu_mode,
    output alu_out,
    input  rsp_valid, rsp_id, rsp_data,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational ALU between two requesters.
// Define ALU_ARB_PERF_EN to add perf_ops / perf_stall counters.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int MODE_W = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  alu_arbiter_if.slave bus
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0] perf_ops,
  output logic [31:0] perf_stall
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic              last_q, last_d;
  logic              pend_q, pend_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [MODE_W-1:0] alu_mode_q, alu_mode_d;

  logic g0, g1;
  logic can_accept;
  logic r0_rdy, r1_rdy;
  logic acc, acc_id;

  // last_q=1 means r1 won last, so r0 wins the next tie
  always_comb begin
    g0 = bus.r0_valid & (~bus.r1_valid | last_q);
    g1 = bus.r1_valid & (~bus.r0_valid | ~last_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (acc) state_d = BUSY;
      BUSY: state_d = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = acc ? BUSY : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    can_accept = (state_q == IDLE) |
                 ((state_q == RESP) & bus.rsp_ready);
    r0_rdy = can_accept & g0;
    r1_rdy = can_accept & g1;
    acc    = r0_rdy | r1_rdy;
    acc_id = r1_rdy;
  end

  always_comb begin
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_mode_d  = alu_mode_q;
    pend_d      = pend_q;
    last_d      = last_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (acc) begin
      alu_a_d    = acc_id ? bus.r1_a : bus.r0_a;
      alu_b_d    = acc_id ? bus.r1_b : bus.r0_b;
      alu_mode_d = acc_id ? bus.r1_mode : bus.r0_mode;
      pend_d     = acc_id;
      last_d     = acc_id;
    end
    if (state_q == BUSY) begin
      rsp_data_d  = bus.alu_out;
      rsp_id_d    = pend_q;
      rsp_valid_d = 1'b1;
    end else if ((state_q == RESP) & bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_mode_q  <= '0;
      pend_q      <= 1'b0;
      last_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_mode_q  <= alu_mode_d;
      pend_q      <= pend_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.r0_ready  = r0_rdy;
  assign bus.r1_ready  = r1_rdy;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_mode  = alu_mode_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;

`ifdef ALU_ARB_PERF_EN
  logic [31:0] perf_ops_q, perf_ops_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic        stall;

  // a stall is any cycle with a pending request that was not granted
  always_comb begin
    stall = (bus.r0_valid & ~r0_rdy) |
            (bus.r1_valid & ~r1_rdy);
    perf_ops_d   = perf_ops_q;
    perf_stall_d = perf_stall_q;
    if (rsp_valid_q & bus.rsp_ready) begin
      perf_ops_d = perf_ops_q + 32'd1;
    end
    if (stall) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_ops_q   <= perf_ops_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_ops   = perf_ops_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU.
// Perf counter checks are built when ALU_ARB_PERF_EN is defined.
module tb_alu_arbiter;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  alu_arbiter_if #(.DATA_W(32), .MODE_W(4)) bus ();

`ifdef ALU_ARB_PERF_EN
  logic [31:0] perf_ops;
  logic [31:0] perf_stall;
`endif

  alu_arbiter #(.DATA_W(32), .MODE_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_ops   (perf_ops),
    .perf_stall (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    case (bus.alu_mode)
      4'd0:    bus.alu_out = bus.alu_a + bus.alu_b;
      4'd1:    bus.alu_out = bus.alu_a - bus.alu_b;
      4'd2:    bus.alu_out = bus.alu_a & bus.alu_b;
      4'd3:    bus.alu_out = bus.alu_a | bus.alu_b;
      default: bus.alu_out = bus.alu_a ^ bus.alu_b;
    endcase
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit id, input bit v,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [3:0] m);
    if (id) begin
      bus.r1_valid = v;
      bus.r1_a     = a;
      bus.r1_b     = b;
      bus.r1_mode  = m;
    end else begin
      bus.r0_valid = v;
      bus.r0_a     = a;
      bus.r0_b     = b;
      bus.r0_mode  = m;
    end
  endtask

  function automatic logic [1:0] rdy();
    return {bus.r1_ready, bus.r0_ready};
  endfunction

  // lone op from IDLE with rsp_ready=1; ends back in IDLE
  task automatic run_op(input bit id,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [3:0] m);
    drive(id, 1'b1, a, b, m);
    tick();
    drive(id, 1'b0, a, b, m);
    tick();
    tick();
  endtask

  logic [1:0] exp_rdy;

  initial begin
    n_chk = 0;
    n_err = 0;
    clk   = 1'b0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, '0, '0, '0);
    bus.rsp_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_alu_a", bus.alu_a, 32'd0);
    check("rst_alu_mode", 32'(bus.alu_mode), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst_rsp_data", bus.rsp_data, 32'd0);
    check("rst_ready", 32'(rdy()), 32'd0);
    rst_n = 1'b1;
    tick();

    // contention: r0 -> 2+3=5, r1 -> 10-4=6
    drive(1'b0, 1'b1, 32'd2, 32'd3, 4'd0);
    drive(1'b1, 1'b1, 32'd10, 32'd4, 4'd1);
    for (int c = 0; c <= 16; c++) begin
      bus.r0_valid = (c < 15);
      bus.r1_valid = (c < 15);
      #1;
      exp_rdy = 2'b00;
      if ((c % 2 == 0) && (c <= 14)) begin
        exp_rdy = ((c / 2) % 2 == 0) ? 2'b01 : 2'b10;
      end
      check("cont_rdy", 32'(rdy()), 32'(exp_rdy));
      if ((c % 2 == 0) && (c >= 2)) begin
        check("cont_rv", 32'(bus.rsp_valid), 32'd1);
        check("cont_id", 32'(bus.rsp_id),
              32'(((c - 2) / 2) % 2));
        check("cont_data", bus.rsp_data,
              (((c - 2) / 2) % 2 == 0) ? 32'd5 : 32'd6);
      end else begin
        check("cont_rv", 32'(bus.rsp_valid), 32'd0);
      end
      tick();
    end

    // single op 2+3
    drive(1'b0, 1'b1, 32'd2, 32'd3, 4'd0);
    #1;
    check("one_rdy", 32'(rdy()), 32'b01);
    tick();
    drive(1'b0, 1'b0, 32'd2, 32'd3, 4'd0);
    check("one_alu_a", bus.alu_a, 32'd2);
    check("one_alu_b", bus.alu_b, 32'd3);
    check("one_rv_busy", 32'(bus.rsp_valid), 32'd0);
    tick();
    check("one_rv", 32'(bus.rsp_valid), 32'd1);
    check("one_id", 32'(bus.rsp_id), 32'd0);
    check("one_data", bus.rsp_data, 32'd5);
    tick();
    check("one_idle_rv", 32'(bus.rsp_valid), 32'd0);

    // lone r0 again after r0 won last: 7|9
    drive(1'b0, 1'b1, 32'd7, 32'd9, 4'd3);
    #1;
    check("lone_rdy", 32'(rdy()), 32'b01);
    tick();
    drive(1'b0, 1'b0, 32'd7, 32'd9, 4'd3);
    tick();
    check("lone_data", bus.rsp_data, 32'd15);
    tick();

    // backpressure: r1 20-16, then r0 8&4 back-to-back
    bus.rsp_ready = 1'b0;
    drive(1'b1, 1'b1, 32'd20, 32'd16, 4'd1);
    #1;
    check("bp_rdy", 32'(rdy()), 32'b10);
    tick();
    drive(1'b1, 1'b0, 32'd20, 32'd16, 4'd1);
    tick();
    drive(1'b0, 1'b1, 32'd8, 32'd4, 4'd2);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_rv", 32'(bus.rsp_valid), 32'd1);
      check("bp_data", bus.rsp_data, 32'd4);
      check("bp_id", 32'(bus.rsp_id), 32'd1);
      check("bp_rdy_hold", 32'(rdy()), 32'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("b2b_rdy", 32'(rdy()), 32'b01);
    check("b2b_rv_pre", 32'(bus.rsp_valid), 32'd1);
    tick();
    drive(1'b0, 1'b0, 32'd8, 32'd4, 4'd2);
    check("b2b_rv_busy", 32'(bus.rsp_valid), 32'd0);
    check("b2b_alu_a", bus.alu_a, 32'd8);
    check("b2b_mode", 32'(bus.alu_mode), 32'd2);
    tick();
    check("b2b_rv", 32'(bus.rsp_valid), 32'd1);
    check("b2b_id", 32'(bus.rsp_id), 32'd0);
    check("b2b_data", bus.rsp_data, 32'd0);
    tick();

    // reset in BUSY (r0 won last before reset)
    drive(1'b0, 1'b1, 32'd5, 32'd5, 4'd0);
    tick();
    drive(1'b0, 1'b0, 32'd5, 32'd5, 4'd0);
    check("mr_alu_a_pre", bus.alu_a, 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_rv", 32'(bus.rsp_valid), 32'd0);
    check("mr_alu_a", bus.alu_a, 32'd0);
    tick();
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    check("mr_lost1", 32'(bus.rsp_valid), 32'd0);
    tick();
    check("mr_lost2", 32'(bus.rsp_valid), 32'd0);
    drive(1'b0, 1'b1, 32'd1, 32'd1, 4'd0);
    drive(1'b1, 1'b1, 32'd9, 32'd3, 4'd1);
    #1;
    check("mr_tie_rdy", 32'(rdy()), 32'b01);
    tick();
    drive(1'b0, 1'b0, 32'd1, 32'd1, 4'd0);
    drive(1'b1, 1'b0, 32'd9, 32'd3, 4'd1);
    tick();
    check("mr_id", 32'(bus.rsp_id), 32'd0);
    check("mr_data", bus.rsp_data, 32'd2);
    tick();

`ifdef ALU_ARB_PERF_EN
    #2;
    rst_n = 1'b0;
    #1;
    check("pf_rst_ops", perf_ops, 32'd0);
    check("pf_rst_stall", perf_stall, 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    drive(1'b0, 1'b1, 32'd1, 32'd2, 4'd0);
    drive(1'b1, 1'b1, 32'd3, 32'd1, 4'd1);
    tick();
    drive(1'b0, 1'b0, 32'd1, 32'd2, 4'd0);
    tick();
    #1;
    check("pf_r1_rdy", 32'(rdy()), 32'b10);
    tick();
    drive(1'b1, 1'b0, 32'd3, 32'd1, 4'd1);
    tick();
    tick();
    run_op(1'b0, 32'd4, 32'd4, 4'd0);
    check("pf_ops", perf_ops, 32'd3);
    check("pf_stall", perf_stall, 32'd2);
    force dut.perf_ops_q = 32'hFFFF_FFFF;
    #1;
    release dut.perf_ops_q;
    check("pf_forced", perf_ops, 32'hFFFF_FFFF);
    run_op(1'b1, 32'd6, 32'd1, 4'd1);
    check("pf_wrap", perf_ops, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
